nw_job_ctrl: RTL and testbench

NW_JOB_CTRL -- requirements
Module: nw_job_ctrl

---
 rtl/nw_pkg.sv | 26 ++
 rtl/nw_rr_arbiter.sv | 52 +++++
 rtl/nw_job_ctrl.sv | 151 +++++++++++++++
 tb/tb_nw_job_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch job controller slice.
// Contents: controller state encoding, traceback direction codes and the
// default widths used as parameter defaults by nw_job_ctrl and nw_rr_arbiter.
package nw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } nw_state_e;

    typedef logic [1:0] nw_dir_t;

    localparam nw_dir_t DIR_TOP    = 2'b00;
    localparam nw_dir_t DIR_LEFT   = 2'b01;
    localparam nw_dir_t DIR_CORNER = 2'b10;

    localparam int NW_LENGTH     = 10;
    localparam int NW_CWIDTH     = 2;
    localparam int NW_SWIDTH     = 16;
    localparam int NW_NREQ       = 2;
    localparam int NW_CLR_CYCLES = 2;
    localparam int NW_TIMEOUT    = 255;

endpackage

// File: rtl/nw_rr_arbiter.sv
// Round-robin arbiter for job requesters.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   req         - request vector, one bit per requester
//   advance     - grant is being taken this cycle; move the pointer past it
//   grant       - one-hot grant (combinational), zero when no request
// The search starts at the pointer, which after reset is index 0 and after
// each taken grant is the index just after the granted one.
module nw_rr_arbiter
    import nw_pkg::*;
#(
    parameter int N = NW_NREQ
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr <= PW'((i + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/nw_job_ctrl.sv
// Job controller for the Needleman-Wunsch scoring grid.
// Accepts jobs from NREQ requesters (round-robin), latches the two strings,
// clears the grid, waits for the grid result (or aborts on timeout) and
// returns the score through a valid/ready response port.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - per-requester job request / one-cycle accept pulse
//   req_s1, req_s2        - per-requester strings, requester i at slice i
//   grid_reset            - clear strobe to the grid, CLR_CYCLES long
//   grid_s1, grid_s2      - latched strings, stable for the whole job
//   grid_score/grid_valid - grid result and completion flag
//   resp_*                - response handshake and payload (id, score, timeout)
//   busy                  - controller is not idle
//
// state | meaning
// IDLE  | waiting for a request; grants one on the clock edge
// CLEAR | grid_reset held high for CLR_CYCLES cycles
// RUN   | counting cycles until grid_valid or TIMEOUT
// DONE  | resp_valid held until resp_ready
module nw_job_ctrl
    import nw_pkg::*;
#(
    parameter int LENGTH     = NW_LENGTH,
    parameter int CWIDTH     = NW_CWIDTH,
    parameter int SWIDTH     = NW_SWIDTH,
    parameter int NREQ       = NW_NREQ,
    parameter int CLR_CYCLES = NW_CLR_CYCLES,
    parameter int TIMEOUT    = NW_TIMEOUT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NREQ-1:0]                          req_valid,
    output logic [NREQ-1:0]                          req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]            req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]            req_s2,
    output logic                                     grid_reset,
    output logic [LENGTH*CWIDTH-1:0]                 grid_s1,
    output logic [LENGTH*CWIDTH-1:0]                 grid_s2,
    input  logic signed [SWIDTH-1:0]                 grid_score,
    input  logic                                     grid_valid,
    output logic                                     resp_valid,
    input  logic                                     resp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id,
    output logic signed [SWIDTH-1:0]                 resp_score,
    output logic                                     resp_timeout,
    output logic                                     busy
);

    localparam int LW  = LENGTH * CWIDTH;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RCW = $clog2(TIMEOUT + 1);
    localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    nw_state_e      state;
    logic [NREQ-1:0] grant;
    logic           advance;
    logic [IDW-1:0] grant_id;
    logic [LW-1:0]  sel_s1;
    logic [LW-1:0]  sel_s2;
    logic [CCW-1:0] clr_cnt;
    logic [RCW-1:0] run_cnt;

    // Only arbitrate in IDLE; the DONE->IDLE handshake cycle therefore never grants.
    assign advance = (state == ST_IDLE) && (|req_valid);
    assign busy    = (state != ST_IDLE);

    nw_rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        grant_id = '0;
        sel_s1   = '0;
        sel_s2   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
                sel_s1   = req_s1[i*LW +: LW];
                sel_s2   = req_s2[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_ready    <= '0;
            grid_reset   <= 1'b0;
            grid_s1      <= '0;
            grid_s2      <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_score   <= '0;
            resp_timeout <= 1'b0;
            clr_cnt      <= '0;
            run_cnt      <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        req_ready  <= grant;
                        grid_s1    <= sel_s1;
                        grid_s2    <= sel_s2;
                        resp_id    <= grant_id;
                        grid_reset <= 1'b1;
                        clr_cnt    <= CCW'(CLR_CYCLES - 1);
                        state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == '0) begin
                        grid_reset <= 1'b0;
                        run_cnt    <= '0;
                        state      <= ST_RUN;
                    end else begin
                        clr_cnt <= clr_cnt - CCW'(1);
                    end
                end
                ST_RUN: begin
                    // grid_valid takes priority over a coincident timeout.
                    if (grid_valid) begin
                        resp_score   <= grid_score;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= ST_DONE;
                    end else if (run_cnt == RCW'(TIMEOUT)) begin
                        resp_score   <= '0;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= ST_DONE;
                    end else if (run_cnt != {RCW{1'b1}}) begin
                        run_cnt <= run_cnt + RCW'(1);
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_ctrl.sv
// Directed testbench for nw_job_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge. "Latency" is counted from the grant cycle (the
// IDLE cycle whose edge produces req_ready) to the first resp_valid cycle.
module tb_nw_job_ctrl;

    localparam int LENGTH     = 10;
    localparam int CWIDTH     = 2;
    localparam int SWIDTH     = 16;
    localparam int NREQ       = 2;
    localparam int CLR_CYCLES = 2;
    localparam int TIMEOUT    = 255;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [39:0]              req_s1;
    logic [39:0]              req_s2;
    logic                     grid_reset;
    logic [19:0]              grid_s1;
    logic [19:0]              grid_s2;
    logic signed [15:0]       grid_score;
    logic                     grid_valid;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [0:0]               resp_id;
    logic signed [15:0]       resp_score;
    logic                     resp_timeout;
    logic                     busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    nw_job_ctrl #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .NREQ(NREQ),
        .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2),
        .grid_reset(grid_reset), .grid_s1(grid_s1), .grid_s2(grid_s2),
        .grid_score(grid_score), .grid_valid(grid_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_score(resp_score), .resp_timeout(resp_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        while (resp_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (req_ready === 2'b00 && n < budget) begin
            step();
            n++;
        end
    endtask

    // Called on the first RUN cycle; asserts grid_valid on RUN count 'delay'.
    task automatic pulse_grid(input int delay, input logic signed [15:0] score);
        repeat (delay) step();
        grid_valid = 1'b1;
        grid_score = score;
        step();
        grid_valid = 1'b0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        grid_valid = 1'b1;
        repeat (3) step();
        n_total++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", req_ready); else n_pass++;
        n_total++; if (grid_reset !== 1'b0) $display("FAIL rst_grid_reset: got %b want 0", grid_reset); else n_pass++;
        n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_total++; if (resp_timeout !== 1'b0) $display("FAIL rst_resp_timeout: got %b want 0", resp_timeout); else n_pass++;
        n_total++; if (resp_score !== 16'sd0) $display("FAIL rst_resp_score: got %0d want 0", resp_score); else n_pass++;
        n_total++; if (resp_id !== 1'b0) $display("FAIL rst_resp_id: got %0d want 0", resp_id); else n_pass++;
        n_total++; if (grid_s1 !== 20'h0 || grid_s2 !== 20'h0) $display("FAIL rst_grid_s: got %h/%h want 0/0", grid_s1, grid_s2); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        req_valid = 2'b00;
        grid_valid = 1'b0;
        reset = 1'b0;
        step();
        n_total++; if (busy !== 1'b0) $display("FAIL rst_idle_after: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ready [3];
        logic [0:0]  exp_id [3];
        logic [19:0] exp_s1 [3];
        exp_ready = '{2'b01, 2'b10, 2'b01};
        exp_id    = '{1'b0, 1'b1, 1'b0};
        exp_s1    = '{20'h12345, 20'h0F0F0, 20'h12345};
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_s1 = {20'h0F0F0, 20'h12345};
        req_s2 = {20'h00FF0, 20'h54321};
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_ready(5);
            n_total++; if (req_ready !== exp_ready[k]) $display("FAIL cont_grant%0d: got %b want %b", k, req_ready, exp_ready[k]); else n_pass++;
            n_total++; if (grid_s1 !== exp_s1[k]) $display("FAIL cont_s1_%0d: got %h want %h", k, grid_s1, exp_s1[k]); else n_pass++;
            step();
            n_total++; if (req_ready !== 2'b00) $display("FAIL cont_pulse%0d: got %b want 00", k, req_ready); else n_pass++;
            step();
            pulse_grid(3, 16'(k + 1));
            wait_resp(10);
            n_total++; if (resp_valid !== 1'b1) $display("FAIL cont_resp%0d: got resp_valid=%b want 1", k, resp_valid); else n_pass++;
            n_total++; if (resp_id !== exp_id[k]) $display("FAIL cont_id%0d: got %0d want %0d", k, resp_id, exp_id[k]); else n_pass++;
            n_total++; if (resp_score !== 16'(k + 1)) $display("FAIL cont_score%0d: got %0d want %0d", k, resp_score, k + 1); else n_pass++;
            handshake();
            n_total++; if (req_ready !== 2'b00) $display("FAIL cont_nograb%0d: got %b want 00 after handshake", k, req_ready); else n_pass++;
            if (k == 2) req_valid = 2'b00;
        end
    endtask

    task automatic test_single();
        int t_ready;
        req_s1 = {20'hAAAAA, 20'h55555};
        req_s2 = {20'hFFFFF, 20'h55555};
        req_valid = 2'b01;
        step();
        t_ready = cyc;
        req_valid = 2'b00;
        n_total++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready); else n_pass++;
        n_total++; if (grid_s1 !== 20'h55555 || grid_s2 !== 20'h55555) $display("FAIL single_strings: got %h/%h want 55555/55555", grid_s1, grid_s2); else n_pass++;
        n_total++; if (grid_reset !== 1'b1) $display("FAIL single_clr0: got %b want 1", grid_reset); else n_pass++;
        step();
        n_total++; if (req_ready !== 2'b00 || grid_reset !== 1'b1) $display("FAIL single_clr1: got ready=%b grid_reset=%b want 00/1", req_ready, grid_reset); else n_pass++;
        step();
        n_total++; if (grid_reset !== 1'b0 || busy !== 1'b1) $display("FAIL single_run: got grid_reset=%b busy=%b want 0/1", grid_reset, busy); else n_pass++;
        repeat (30) step();
        n_total++; if (resp_valid !== 1'b0) $display("FAIL single_early: got resp_valid=%b want 0", resp_valid); else n_pass++;
        grid_valid = 1'b1;
        grid_score = 16'sd10;
        step();
        grid_valid = 1'b0;
        wait_resp(50);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL single_resp: got resp_valid=%b want 1", resp_valid); else n_pass++;
        n_total++; if (cyc - t_ready + 1 != 34) $display("FAIL single_latency: got %0d want 34", cyc - t_ready + 1); else n_pass++;
        n_total++; if (resp_score !== 16'sd10 || resp_timeout !== 1'b0 || resp_id !== 1'b0) $display("FAIL single_payload: got score=%0d to=%b id=%0d want 10/0/0", resp_score, resp_timeout, resp_id); else n_pass++;
        handshake();
        n_total++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_hs: got resp_valid=%b busy=%b want 0/0", resp_valid, busy); else n_pass++;
    endtask

    task automatic test_ignore_early_valid();
        int t_ready;
        grid_valid = 1'b1;
        grid_score = 16'sd99;
        req_valid = 2'b01;
        step();
        t_ready = cyc;
        req_valid = 2'b00;
        step();
        step();
        grid_valid = 1'b0;
        pulse_grid(5, -16'sd3);
        wait_resp(20);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL ignore_resp: got resp_valid=%b want 1", resp_valid); else n_pass++;
        n_total++; if (cyc - t_ready + 1 != 9) $display("FAIL ignore_latency: got %0d want 9", cyc - t_ready + 1); else n_pass++;
        n_total++; if (resp_score !== -16'sd3) $display("FAIL ignore_score: got %0d want -3", resp_score); else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        logic ok;
        req_s1 = {20'hAAAAA, 20'h55555};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        step();
        pulse_grid(2, 16'sd77);
        wait_resp(10);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL bp_resp: got resp_valid=%b want 1", resp_valid); else n_pass++;
        ok = 1'b1;
        req_valid = 2'b11;
        req_s1 = {20'h11111, 20'h22222};
        repeat (20) begin
            step();
            if (resp_valid !== 1'b1 || resp_score !== 16'sd77 || resp_timeout !== 1'b0 ||
                resp_id !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00 || grid_s1 !== 20'h55555)
                ok = 1'b0;
        end
        n_total++; if (ok !== 1'b1) $display("FAIL bp_stable: got ok=%b want 1 (valid=%b score=%0d ready=%b)", ok, resp_valid, resp_score, req_ready); else n_pass++;
        req_valid = 2'b00;
        handshake();
        n_total++; if (resp_valid !== 1'b0) $display("FAIL bp_release: got resp_valid=%b want 0", resp_valid); else n_pass++;
    endtask

    task automatic test_timeout();
        int t_ready;
        grid_score = 16'sh1234;
        req_valid = 2'b10;
        step();
        t_ready = cyc;
        req_valid = 2'b00;
        n_total++; if (req_ready !== 2'b10) $display("FAIL to_ready: got %b want 10", req_ready); else n_pass++;
        wait_resp(300);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL to_resp: got resp_valid=%b want 1", resp_valid); else n_pass++;
        n_total++; if (cyc - t_ready + 1 != 259) $display("FAIL to_latency: got %0d want 259", cyc - t_ready + 1); else n_pass++;
        n_total++; if (resp_timeout !== 1'b1 || resp_score !== 16'sd0 || resp_id !== 1'b1) $display("FAIL to_payload: got to=%b score=%0d id=%0d want 1/0/1", resp_timeout, resp_score, resp_id); else n_pass++;
        handshake();
    endtask

    task automatic test_tie();
        int t_ready;
        req_valid = 2'b01;
        step();
        t_ready = cyc;
        req_valid = 2'b00;
        step();
        step();
        pulse_grid(255, 16'sd321);
        wait_resp(5);
        n_total++; if (resp_valid !== 1'b1) $display("FAIL tie_resp: got resp_valid=%b want 1", resp_valid); else n_pass++;
        n_total++; if (cyc - t_ready + 1 != 259) $display("FAIL tie_latency: got %0d want 259", cyc - t_ready + 1); else n_pass++;
        n_total++; if (resp_timeout !== 1'b0 || resp_score !== 16'sd321) $display("FAIL tie_payload: got to=%b score=%0d want 0/321", resp_timeout, resp_score); else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid_run();
        int clr;
        req_s1 = {20'h3C3C3, 20'h55555};
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        step();
        repeat (10) step();
        n_total++; if (busy !== 1'b1 || resp_id !== 1'b1) $display("FAIL mid_prerst: got busy=%b id=%0d want 1/1", busy, resp_id); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0 || req_ready !== 2'b00 || grid_reset !== 1'b0 || resp_valid !== 1'b0) $display("FAIL mid_rst_ctrl: got busy=%b ready=%b grst=%b rv=%b want 0/00/0/0", busy, req_ready, grid_reset, resp_valid); else n_pass++;
        n_total++; if (resp_id !== 1'b0 || resp_score !== 16'sd0 || resp_timeout !== 1'b0) $display("FAIL mid_rst_payload: got id=%0d score=%0d to=%b want 0/0/0", resp_id, resp_score, resp_timeout); else n_pass++;
        n_total++; if (grid_s1 !== 20'h0 || grid_s2 !== 20'h0) $display("FAIL mid_rst_grid: got %h/%h want 0/0", grid_s1, grid_s2); else n_pass++;
        step();
        reset = 1'b0;
        grid_valid = 1'b1;
        grid_score = 16'sd44;
        step();
        grid_valid = 1'b0;
        repeat (3) step();
        n_total++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_no_resp: got rv=%b busy=%b want 0/0", resp_valid, busy); else n_pass++;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        clr = 0;
        for (int i = 0; i < 10 && grid_reset === 1'b1; i++) begin
            clr++;
            step();
        end
        n_total++; if (clr != 2) $display("FAIL mid_clr_len: got %0d want 2", clr); else n_pass++;
        pulse_grid(1, 16'sd5);
        wait_resp(10);
        n_total++; if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_score !== 16'sd5) $display("FAIL mid_next_job: got rv=%b id=%0d score=%0d want 1/1/5", resp_valid, resp_id, resp_score); else n_pass++;
        handshake();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_s1     = '0;
        req_s2     = '0;
        grid_score = '0;
        grid_valid = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_ignore_early_valid();
        test_backpressure();
        test_timeout();
        test_tie();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
